pe_array_mem_scheduler: RTL and testbench
=========================================

# pe_array_mem_scheduler

Sequences a group of NUM_PE processing elements that share one single-port word memory: starts them together, round-robin arbitrates their buffer-load (read) and store-to-memory (write) requests onto the memory port, and reports completion once every PE has finished. Sits between the PE array and the shared memory in the convolution accelerator top level.

## Interface
- NUM_PE, 4: number of PEs sharing the memory port (2..8).
- ADDR_W, 12: memory address width.
- IN_WORDS, 64: input-region words per PE; PE i reads region base i*IN_WORDS.
- OUT_BASE, 2048: base address of the output region.
- OUT_WORDS, 16: output-region words per PE; PE i writes region base OUT_BASE + i*OUT_WORDS.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- done  out  1  one-cycle pulse when the run completes.
- pe_start  out  NUM_PE  one-cycle start pulse to every PE.
- pe_done  in  NUM_PE  per-PE done (pulse or level; latched internally).
- pe_load_req  in  NUM_PE  PE i requests the next input word.
- pe_store_req  in  NUM_PE  PE i has a result word to write.
- pe_res  in  32*NUM_PE  result words; PE i at bits [32*i+31 : 32*i].
- pe_load_valid  out  NUM_PE  one-hot; pe_mem_data valid for that PE this cycle.
- pe_mem_data  out  32  broadcast read data (= mem_rdata).
- pe_store_ack  out  NUM_PE  one-hot; PE i's store accepted this cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read strobe; data returned next cycle on mem_rdata.
- mem_wr  out  1  write strobe.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, 1-cycle latency.

## Operation
- FSM IDLE -> LAUNCH -> RUN -> FINISH -> IDLE.
- IDLE: start=1 -> LAUNCH; start in any other state is ignored.
- LAUNCH (1 cycle): pe_start all ones; clear per-PE read/write pointers, done-latches, outstanding-read flag; round-robin pointer is not cleared. -> RUN.
- RUN: each cycle at most one grant. Eligible PE i: (pe_load_req[i] or pe_store_req[i]) and no outstanding read for PE i. Winner = first eligible PE scanning from rr_ptr upward with wrap; rr_ptr <= winner+1 mod NUM_PE after a grant; unchanged if no grant.
- Winner with pe_store_req: mem_wr=1, mem_addr = OUT_BASE + i*OUT_WORDS + wptr[i], mem_wdata = pe_res[i], pe_store_ack[i]=1 same cycle; wptr[i] increments, wraps to 0 after OUT_WORDS-1.
- Winner with only pe_load_req: mem_rd=1, mem_addr = i*IN_WORDS + rptr[i]; rptr[i] increments, wraps after IN_WORDS-1; PE i flagged outstanding.
- A store and a load from the same PE in the same cycle: store wins; load stays pending.
- Cycle after a read grant: pe_load_valid[i]=1, pe_mem_data = mem_rdata, outstanding flag cleared. A new grant may issue in that same cycle (reads pipeline back-to-back across different PEs).
- pe_done[i] sets done_latch[i]; requests from finished PEs are still served.
- RUN -> FINISH when all done_latch set, no read outstanding, and no grant this cycle.
- FINISH (1 cycle): done=1. -> IDLE.
- Requesters hold req until pe_store_ack / pe_load_valid; the scheduler never drops a held request.
- Address arithmetic modulo 2^ADDR_W.

## Timing
- Reset: every output 0; FSM IDLE; rr_ptr 0; all pointers, latches, flags 0. rst mid-run aborts immediately with the same values; an in-flight read is discarded (no pe_load_valid).
- start to pe_start: 1 cycle (start at cycle t, LAUNCH at t+1).
- Store latency: ack in grant cycle. Load latency: data 1 cycle after grant.
- Throughput: one memory access per cycle.
- Starvation bound: a held request is granted within NUM_PE RUN cycles.
- Last event to done: ≥ 1 cycle (FINISH follows the cycle all conditions hold).

## Test plan
- NUM_PE=4, only PE2 raises pe_load_req for 3 words -> mem_rd at addr 128,129,130; pe_load_valid=4'b0100 one cycle after each grant; no re-grant while outstanding.
- All 4 PEs hold pe_load_req continuously after reset -> grant order 0,1,2,3,0...; never two grants to one PE with a read outstanding.
- PE1 asserts store and load together with pe_res[1]=32'hDEADBEEF -> mem_wr, addr 2064, wdata DEADBEEF, pe_store_ack=4'b0010; load granted on a later cycle.
- PE0 performs 17 stores -> 17th write at addr 2048 (wptr wrap).
- pe_done pulses arrive at different cycles, the last with a read outstanding -> done pulses exactly once, only after that read's pe_load_valid; start during RUN ignored.
- rst asserted during RUN with read in flight -> next cycle all outputs 0, no pe_load_valid; new start produces pe_start after 1 cycle.

Source files
------------

// File: rtl/pe_array_mem_scheduler_if.sv
// PE-array / shared-memory bundle between the scheduler (master) and the PE array plus memory (slave).
interface pe_array_mem_scheduler_if #(
  parameter int NUM_PE = 4,
  parameter int ADDR_W = 12
);
  logic [NUM_PE-1:0]    pe_start;
  logic [NUM_PE-1:0]    pe_done;
  logic [NUM_PE-1:0]    pe_load_req;
  logic [NUM_PE-1:0]    pe_store_req;
  logic [32*NUM_PE-1:0] pe_res;
  logic [NUM_PE-1:0]    pe_load_valid;
  logic [31:0]          pe_mem_data;
  logic [NUM_PE-1:0]    pe_store_ack;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport master (
    output pe_start, pe_load_valid, pe_mem_data, pe_store_ack,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  pe_done, pe_load_req, pe_store_req, pe_res, mem_rdata
  );

  modport slave (
    input  pe_start, pe_load_valid, pe_mem_data, pe_store_ack,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output pe_done, pe_load_req, pe_store_req, pe_res, mem_rdata
  );
endinterface

// File: rtl/pe_array_mem_scheduler.sv
// Launches NUM_PE PEs and round-robins their loads/stores onto one memory port; done once all PEs finish.
// Stores ack in the grant cycle, load data returns one cycle later; held requests wait, never dropped.
module pe_array_mem_scheduler #(
  parameter int NUM_PE    = 4,
  parameter int ADDR_W    = 12,
  parameter int IN_WORDS  = 64,
  parameter int OUT_BASE  = 2048,
  parameter int OUT_WORDS = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic                       o_done,
  pe_array_mem_scheduler_if.master   bus
);

  localparam int PW = (NUM_PE > 1)    ? $clog2(NUM_PE)    : 1;
  localparam int RW = (IN_WORDS > 1)  ? $clog2(IN_WORDS)  : 1;
  localparam int WW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_rr_ptr;
  logic [RW-1:0]     r_rptr [NUM_PE];
  logic [WW-1:0]     r_wptr [NUM_PE];
  logic [NUM_PE-1:0] r_done_latch;
  logic [NUM_PE-1:0] r_rd_pend;

  logic [NUM_PE-1:0] w_elig;
  logic              w_grant;
  logic [PW-1:0]     w_win;
  int                w_idx;
  logic              w_win_store;
  logic [RW-1:0]     w_rptr_sel;
  logic [WW-1:0]     w_wptr_sel;
  logic [31:0]       w_res;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  // A PE with a read in flight sits out until its data has been returned.
  always_comb begin
    w_elig  = (bus.pe_load_req | bus.pe_store_req) & ~r_rd_pend;
    w_grant = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    if (r_state == S_RUN) begin
      for (int k = 0; k < NUM_PE; k++) begin
        w_idx = int'(r_rr_ptr) + k;
        if (w_idx >= NUM_PE) w_idx = w_idx - NUM_PE;
        if (!w_grant && w_elig[PW'(w_idx)]) begin
          w_grant = 1'b1;
          w_win   = PW'(w_idx);
        end
      end
    end
  end

  always_comb begin
    w_rptr_sel  = '0;
    w_wptr_sel  = '0;
    w_res       = '0;
    w_win_store = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (PW'(i) == w_win) begin
        w_rptr_sel  = r_rptr[i];
        w_wptr_sel  = r_wptr[i];
        w_res       = bus.pe_res[32*i +: 32];
        w_win_store = bus.pe_store_req[i];
      end
    end
    w_rd_addr = ADDR_W'(int'(w_win) * IN_WORDS + int'(w_rptr_sel));
    w_wr_addr = ADDR_W'(OUT_BASE + int'(w_win) * OUT_WORDS + int'(w_wptr_sel));
  end

  always_comb begin
    w_state_nxt       = r_state;
    o_done            = 1'b0;
    bus.pe_start      = '0;
    bus.pe_store_ack  = '0;
    bus.mem_rd        = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.pe_load_valid = r_rd_pend;
    bus.pe_mem_data   = (|r_rd_pend) ? bus.mem_rdata : '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.pe_start = '1;
        w_state_nxt  = S_RUN;
      end
      S_RUN: begin
        if (w_grant) begin
          // A store beats a simultaneous load from the same PE; the load stays pending.
          if (w_win_store) begin
            bus.mem_wr              = 1'b1;
            bus.mem_addr            = w_wr_addr;
            bus.mem_wdata           = w_res;
            bus.pe_store_ack[w_win] = 1'b1;
          end else begin
            bus.mem_rd   = 1'b1;
            bus.mem_addr = w_rd_addr;
          end
        end else if ((&r_done_latch) && !(|r_rd_pend)) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_done_latch <= '0;
      r_rd_pend    <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        r_rptr[i] <= '0;
        r_wptr[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= '0;
      case (r_state)
        S_LAUNCH: begin
          r_done_latch <= '0;
          for (int i = 0; i < NUM_PE; i++) begin
            r_rptr[i] <= '0;
            r_wptr[i] <= '0;
          end
        end
        S_RUN: begin
          r_done_latch <= r_done_latch | bus.pe_done;
          if (w_grant) begin
            r_rr_ptr <= (w_win == PW'(NUM_PE - 1)) ? '0 : w_win + 1'b1;
            for (int i = 0; i < NUM_PE; i++) begin
              if (PW'(i) == w_win) begin
                if (w_win_store) begin
                  r_wptr[i] <= (r_wptr[i] == WW'(OUT_WORDS - 1)) ? '0 : r_wptr[i] + 1'b1;
                end else begin
                  r_rptr[i]    <= (r_rptr[i] == RW'(IN_WORDS - 1)) ? '0 : r_rptr[i] + 1'b1;
                  r_rd_pend[i] <= 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_mem_scheduler.sv
// Bench for pe_array_mem_scheduler: directed vector table, hand sequences, and random traffic vs a reference model.
module tb_pe_array_mem_scheduler;

  logic clk = 1'b0;
  logic rst, start, done;
  logic [3:0]  lreq, sreq, pdone;
  logic [31:0] res [4];
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  pe_array_mem_scheduler_if #(.NUM_PE(4), .ADDR_W(12)) bus();

  pe_array_mem_scheduler #(
    .NUM_PE(4), .ADDR_W(12), .IN_WORDS(64), .OUT_BASE(2048), .OUT_WORDS(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_done(done), .bus(bus.master)
  );

  assign bus.pe_load_req  = lreq;
  assign bus.pe_store_req = sreq;
  assign bus.pe_done      = pdone;
  assign bus.pe_res       = {res[3], res[2], res[1], res[0]};
  assign bus.mem_rdata    = rdata;

  always #5 clk = ~clk;

  // Reference model: run state 0 idle, 1 launch, 2 run, 3 finish.
  int          m_state, m_rptr [4], m_wptr [4];
  logic [1:0]  m_rr, m_pend;
  logic        m_pend_v;
  logic [3:0]  m_dl;
  logic [3:0]  e_start, e_ack, e_lv;
  logic        e_done, e_rd, e_wr, e_grant;
  logic [1:0]  e_win;
  logic [11:0] e_addr;
  logic [31:0] e_wdata;

  typedef struct {
    logic [3:0]  l, s, d;
    logic        rd, wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ack, lv;
    logic        dn;
  } vec_t;
  vec_t tbl [12];

  function automatic vec_t mk(logic [3:0] l, logic [3:0] s, logic [3:0] d, logic rd, logic wr,
                              logic [11:0] addr, logic [31:0] wdata, logic [3:0] ack,
                              logic [3:0] lv, logic dn);
    vec_t v;
    v.l = l; v.s = s; v.d = d; v.rd = rd; v.wr = wr; v.addr = addr;
    v.wdata = wdata; v.ack = ack; v.lv = lv; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rr = 2'd0; m_pend = 2'd0; m_pend_v = 1'b0; m_dl = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_rptr[i] = 0;
      m_wptr[i] = 0;
    end
  endtask

  task automatic model_eval();
    logic [1:0] p;
    e_start = 4'h0; e_ack = 4'h0; e_lv = 4'h0; e_done = 1'b0;
    e_rd = 1'b0; e_wr = 1'b0; e_grant = 1'b0; e_win = 2'd0; e_addr = 12'h0; e_wdata = 32'h0;
    if (m_state == 1) e_start = 4'hF;
    if (m_state == 3) e_done = 1'b1;
    if (m_state == 2) begin
      if (m_pend_v) e_lv[m_pend] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        p = m_rr + 2'(k);
        if (!e_grant && (lreq[p] || sreq[p]) && !(m_pend_v && m_pend == p)) begin
          e_grant = 1'b1;
          e_win   = p;
        end
      end
      if (e_grant) begin
        if (sreq[e_win]) begin
          e_wr = 1'b1;
          e_addr = 12'(2048 + 16 * int'(e_win) + m_wptr[e_win]);
          e_wdata = res[e_win];
          e_ack[e_win] = 1'b1;
        end else begin
          e_rd = 1'b1;
          e_addr = 12'(64 * int'(e_win) + m_rptr[e_win]);
        end
      end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        for (int i = 0; i < 4; i++) begin
          m_rptr[i] = 0;
          m_wptr[i] = 0;
        end
        m_dl = 4'h0; m_pend_v = 1'b0; m_state = 2;
      end
      2: begin
        if (!e_grant && m_dl == 4'hF && !m_pend_v) m_state = 3;
        m_pend_v = 1'b0;
        if (e_grant) begin
          m_rr = e_win + 2'd1;
          if (e_wr) m_wptr[e_win] = (m_wptr[e_win] + 1) % 16;
          else begin
            m_rptr[e_win] = (m_rptr[e_win] + 1) % 64;
            m_pend = e_win;
            m_pend_v = 1'b1;
          end
        end
        m_dl = m_dl | pdone;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    if (done === 1'b1) done_cnt++;
    chk("pe_start", 64'(bus.pe_start), 64'(e_start));
    chk("done", 64'(done), 64'(e_done));
    chk("mem_rd", 64'(bus.mem_rd), 64'(e_rd));
    chk("mem_wr", 64'(bus.mem_wr), 64'(e_wr));
    chk("store_ack", 64'(bus.pe_store_ack), 64'(e_ack));
    chk("load_valid", 64'(bus.pe_load_valid), 64'(e_lv));
    if (e_rd || e_wr) chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
    if (e_wr) chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
    if (e_lv != 4'h0) chk("pe_mem_data", 64'(bus.pe_mem_data), 64'(rdata));
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
    rdata = $urandom;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pe_start"}, 64'(bus.pe_start), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rd"}, 64'(bus.mem_rd), 64'd0);
    chk({tag, "_wr"}, 64'(bus.mem_wr), 64'd0);
    chk({tag, "_ack"}, 64'(bus.pe_store_ack), 64'd0);
    chk({tag, "_lv"}, 64'(bus.pe_load_valid), 64'd0);
    chk({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, "_mdata"}, 64'(bus.pe_mem_data), 64'd0);
  endtask

  task automatic agent(input bit allow);
    for (int i = 0; i < 4; i++) begin
      if (e_ack[i]) sreq[i] = 1'b0;
      if (e_lv[i])  lreq[i] = 1'b0;
      if (allow) begin
        if (!sreq[i] && $urandom_range(3) == 0) begin
          sreq[i] = 1'b1;
          res[i]  = $urandom;
        end
        if (!lreq[i] && $urandom_range(2) == 0) lreq[i] = 1'b1;
      end
    end
    // PE3 never finishes early, so the run cannot end before the drain phase.
    pdone = (allow && $urandom_range(15) == 0) ? 4'(1 << $urandom_range(2)) : 4'h0;
    start = allow && ($urandom_range(19) == 0);
  endtask

  task automatic random_run(input int ncyc);
    bit seen;
    start = 1'b1; cyc(); start = 1'b0; cyc();
    for (int n = 0; n < ncyc; n++) begin
      agent(1'b1);
      cyc();
    end
    for (int n = 0; n < 40 && (lreq | sreq) != 4'h0; n++) begin
      agent(1'b0);
      cyc();
    end
    agent(1'b0);
    chk("rand_drain", 64'(lreq | sreq), 64'd0);
    pdone = 4'hF;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      sample();
      seen = seen | (done === 1'b1);
      advance();
      pdone = 4'h0;
    end
    chk("rand_run_done", 64'(seen), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(4'b0100, 4'b0000, 4'b0000, 1, 0, 12'd128,  32'h0, 4'b0000, 4'b0000, 0);
    tbl[1]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 0, 12'd0,    32'h0, 4'b0000, 4'b0100, 0);
    tbl[2]  = mk(4'b0100, 4'b0000, 4'b0000, 1, 0, 12'd129,  32'h0, 4'b0000, 4'b0000, 0);
    tbl[3]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 0, 12'd0,    32'h0, 4'b0000, 4'b0100, 0);
    tbl[4]  = mk(4'b0100, 4'b0000, 4'b0000, 1, 0, 12'd130,  32'h0, 4'b0000, 4'b0000, 0);
    tbl[5]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 12'd0,    32'h0, 4'b0000, 4'b0100, 0);
    tbl[6]  = mk(4'b0010, 4'b0010, 4'b0000, 0, 1, 12'd2064, 32'hDEADBEEF, 4'b0010, 4'b0000, 0);
    tbl[7]  = mk(4'b0010, 4'b0000, 4'b0000, 1, 0, 12'd64,   32'h0, 4'b0000, 4'b0000, 0);
    tbl[8]  = mk(4'b0010, 4'b0000, 4'b1111, 0, 0, 12'd0,    32'h0, 4'b0000, 4'b0010, 0);
    tbl[9]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 12'd0,    32'h0, 4'b0000, 4'b0000, 0);
    tbl[10] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 12'd0,    32'h0, 4'b0000, 4'b0000, 1);
    tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 12'd0,    32'h0, 4'b0000, 4'b0000, 0);

    rst = 1'b1; start = 1'b0; lreq = 4'h0; sreq = 4'h0; pdone = 4'h0;
    rdata = 32'hA5A5_0001;
    res[0] = 32'h1111_0000; res[1] = 32'hDEADBEEF; res[2] = 32'h2222_0000; res[3] = 32'h3333_0000;
    model_reset();
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;
    sample();
    chk_all_zero("reset");
    advance();

    // Directed vector table: single-PE loads, store/load collision, completion.
    start = 1'b1; sample(); chk("idle_pe_start", 64'(bus.pe_start), 64'd0); advance();
    start = 1'b0; sample(); chk("launch_pe_start", 64'(bus.pe_start), 64'hF); advance();
    for (int t = 0; t < 12; t++) begin
      lreq = tbl[t].l; sreq = tbl[t].s; pdone = tbl[t].d;
      sample();
      chk($sformatf("tbl%0d_rd", t), 64'(bus.mem_rd), 64'(tbl[t].rd));
      chk($sformatf("tbl%0d_wr", t), 64'(bus.mem_wr), 64'(tbl[t].wr));
      chk($sformatf("tbl%0d_ack", t), 64'(bus.pe_store_ack), 64'(tbl[t].ack));
      chk($sformatf("tbl%0d_lv", t), 64'(bus.pe_load_valid), 64'(tbl[t].lv));
      chk($sformatf("tbl%0d_done", t), 64'(done), 64'(tbl[t].dn));
      if (tbl[t].rd || tbl[t].wr) chk($sformatf("tbl%0d_addr", t), 64'(bus.mem_addr), 64'(tbl[t].addr));
      if (tbl[t].wr) chk($sformatf("tbl%0d_wdata", t), 64'(bus.mem_wdata), 64'(tbl[t].wdata));
      advance();
    end
    lreq = 4'h0; sreq = 4'h0; pdone = 4'h0;

    // Round-robin with all four PEs loading continuously from a fresh reset.
    rst = 1'b1; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; cyc();
    lreq = 4'hF;
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("rr_rd", 64'(bus.mem_rd), 64'd1);
      chk("rr_addr", 64'(bus.mem_addr), 64'((k % 4) * 64 + k / 4));
      if (k > 0) chk("rr_lv", 64'(bus.pe_load_valid), 64'(1 << ((k - 1) % 4)));
      advance();
    end
    lreq = 4'b1000;
    sample(); chk("rr_last_lv", 64'(bus.pe_load_valid), 64'h8); chk("rr_no_regrant", 64'(bus.mem_rd), 64'd0); advance();

    // Staggered done pulses, the last one alongside a read; start during RUN is ignored.
    done_cnt = 0;
    lreq = 4'h0; pdone = 4'b0001; cyc();
    pdone = 4'b0010; start = 1'b1; cyc(); start = 1'b0;
    pdone = 4'b0100; sample(); chk("start_ignored", 64'(bus.pe_start), 64'd0); advance();
    lreq = 4'b1000; pdone = 4'b1000;
    sample(); chk("late_rd", 64'(bus.mem_rd), 64'd1); chk("late_addr", 64'(bus.mem_addr), 64'd194); advance();
    pdone = 4'h0;
    sample(); chk("late_lv", 64'(bus.pe_load_valid), 64'h8); chk("late_no_done0", 64'(done), 64'd0); advance();
    lreq = 4'h0;
    sample(); chk("late_no_done1", 64'(done), 64'd0); advance();
    sample(); chk("late_done", 64'(done), 64'd1); advance();
    sample(); advance();
    chk("done_once", 64'(done_cnt), 64'd1);

    // Seventeen back-to-back stores from PE0: the write pointer wraps.
    start = 1'b1; cyc(); start = 1'b0; cyc();
    sreq = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      res[0] = 32'h1000 + 32'(k);
      sample();
      chk("st_wr", 64'(bus.mem_wr), 64'd1);
      chk("st_addr", 64'(bus.mem_addr), 64'(2048 + k % 16));
      chk("st_wdata", 64'(bus.mem_wdata), 64'(32'h1000 + 32'(k)));
      chk("st_ack", 64'(bus.pe_store_ack), 64'h1);
      advance();
    end

    // Reset in the cycle a read is granted: the read is discarded.
    sreq = 4'h0; lreq = 4'b0100; rst = 1'b1;
    sample(); chk("rst_rd_grant", 64'(bus.mem_rd), 64'd1); chk("rst_rd_addr", 64'(bus.mem_addr), 64'd128); advance();
    rst = 1'b0; lreq = 4'h0;
    sample(); chk_all_zero("midrst"); advance();
    start = 1'b1; sample(); chk("restart_idle", 64'(bus.pe_start), 64'd0); advance();
    start = 1'b0; sample(); chk("restart_launch", 64'(bus.pe_start), 64'hF); advance();
    pdone = 4'hF; cyc(); pdone = 4'h0; cyc(); cyc();

    for (int r = 0; r < 4; r++) random_run(250);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
